ivd_assay_sequencer: RTL and testbench
======================================

Name: ivd_assay_sequencer

Overview:
- Time-multiplexed controller for an N-channel in-vitro diagnostic array. Each channel is a mixer pair (two inlets) feeding one detector.
- Per enabled channel it runs fill -> mix -> settle -> detector sample -> result report, scanning channels in ascending index order.
- It sits between the host/test interface and the valve, mixer and detector drivers.
- It generalises the fixed 12-mixer/12-detector assay to a parametrised channel count with programmable timing.

Parameters:
- N_CH, 12, number of mixer/detector channels (1..64)
- CNT_W, 16, width of the timing configuration fields and the phase counter
- DATA_W, 12, detector reading width
- DET_TIMEOUT, 1023, maximum cycles to wait for det_valid after det_sample

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle
- abort  in  1  synchronous abort request
- ch_enable  in  N_CH  channel mask, sampled at start
- fill_cycles  in  CNT_W  inlet-open duration, sampled at start
- mix_cycles  in  CNT_W  mixer-on duration, sampled at start
- settle_cycles  in  CNT_W  post-mix idle duration, sampled at start
- valve_a  out  N_CH  inlet A valve open, one-hot or zero
- valve_b  out  N_CH  inlet B valve open, one-hot or zero
- mixer_en  out  N_CH  mixer actuation, one-hot or zero
- det_sample  out  N_CH  one-cycle detector trigger, one-hot
- det_valid  in  1  detector reading ready
- det_data  in  DATA_W  detector reading
- res_valid  out  1  result available
- res_ready  in  1  result accepted
- res_ch  out  $clog2(N_CH)  channel index of the result
- res_data  out  DATA_W  captured reading
- res_timeout  out  1  result is a timeout (res_data = 0)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; all counters, channel pointer and config registers cleared.
- States: IDLE, FILL, MIX, SETTLE, SAMPLE, WAIT_DET, REPORT, NEXT, FINISH.
- IDLE:
  - When start is high, latch the configuration and the mask.
  - Set the pointer to the lowest enabled channel; go to FILL.
  - If the mask is zero, go to FINISH instead.
  - start is ignored in every other state.
- Duration fields: a field value of 0 is treated as 1. Each timed state lasts exactly max(field,1) cycles.
- FILL: valve_a[ch] = valve_b[ch] = 1 for the fill duration, then MIX.
- MIX: valves closed; mixer_en[ch] = 1 for the mix duration, then SETTLE.
- SETTLE: all actuators off for the settle duration, then SAMPLE.
- SAMPLE: det_sample[ch] = 1 for one cycle, then WAIT_DET with the timeout counter cleared.
- WAIT_DET:
  - If det_valid is high in any cycle, capture det_data and set res_timeout = 0.
  - Otherwise, after DET_TIMEOUT cycles, set res_data = 0 and res_timeout = 1.
  - Either outcome goes to REPORT.
  - det_valid arriving in the same cycle as det_sample is ignored.
- REPORT:
  - res_valid = 1, with res_ch, res_data and res_timeout stable until the cycle res_ready is high.
  - On acceptance, drop res_valid next cycle and go to NEXT.
  - A stall is unbounded; actuators stay off while stalled.
- NEXT:
  - Advance to the next higher enabled channel and go to FILL.
  - If none remains, go to FINISH. There is no wrap-around.
- FINISH: done = 1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- Per-channel latency with res_ready held high: fill + mix + settle + 1 + det_latency + 1 (REPORT) + 1 (NEXT) cycles.
- Abort:
  - Sampled in any non-IDLE state and takes priority over all other transitions.
  - Next cycle: state IDLE, all actuators and res_valid 0, done not pulsed.
  - An abort coinciding with res_ready still discards the result.
  - start and abort together in IDLE: abort wins, and the run does not start.
- Actuator outputs are registered and never more than one-hot across all actuator vectors combined.

Decomposition:
- Shared package ivd_pkg holds:
  - the state enum;
  - the function sat1(x) = max(x,1);
  - the constant CH_W = $clog2(N_CH), min 1.
- One sub-module, ivd_next_channel: combinational priority search returning the next enabled index above a given pointer, plus a none_left flag. It is reused for both the first-channel and next-channel lookups.

Test Plan:
- N_CH=12, mask=12'h005, fill=3, mix=4, settle=2; det_valid returns 2 cycles after det_sample with 12'h0A5/12'h3C1; res_ready=1.
  - Expect results for ch0 then ch2, data 0A5/3C1.
  - Expect valve_a[0] high for exactly 3 cycles and mixer_en[0] high for exactly 4.
  - Expect one done pulse; channel 1 never actuated.
- mask=0, start -> busy for the FINISH cycle only, done pulses once, no actuator or res_valid activity.
- fill=mix=settle=0, single channel -> each phase lasts 1 cycle.
- det_valid never asserted, DET_TIMEOUT=15 -> REPORT after 15 WAIT_DET cycles, res_timeout=1, res_data=0, then sequencing continues.
- res_ready held low for 20 cycles -> res_valid and payload stable for 20 cycles, no next-channel FILL until acceptance.
- abort asserted mid-MIX on ch5 -> next cycle all outputs 0, busy=0, no done; a fresh start then runs normally from the lowest enabled channel.
- rst_n pulsed low asynchronously mid-FILL -> valves drop without waiting for a clock edge.

Source files
------------

// File: rtl/ivd_pkg.sv
// Shared types and helpers for the IVD assay sequencer.
package ivd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_MIX,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_DET,
        ST_REPORT,
        ST_NEXT,
        ST_FINISH
    } state_e;

    localparam int unsigned N_CH_DEFAULT = 12;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W = ch_width(N_CH_DEFAULT);

    // Durations of zero run as one cycle.
    function automatic logic [31:0] sat1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/ivd_assay_sequencer_next_channel.sv
// Priority search for the lowest enabled channel, from zero or above a pointer.
module ivd_next_channel
    import ivd_pkg::*;
#(
    parameter int unsigned N_CH   = N_CH_DEFAULT,
    parameter int unsigned CHAN_W = CH_W
) (
    input  logic [N_CH-1:0]   mask,
    input  logic [CHAN_W-1:0] ptr,
    input  logic              first,
    output logic [CHAN_W-1:0] next_idx_c,
    output logic              none_left_c
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx_c  = '0;
        none_left_c = 1'b1;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(ptr)))) begin
                next_idx_c  = CHAN_W'(i);
                none_left_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ivd_assay_sequencer.sv
// Time-multiplexed fill/mix/settle/sample/report controller for an N-channel assay array.
module ivd_assay_sequencer
    import ivd_pkg::*;
#(
    parameter int unsigned N_CH        = 12,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned DET_TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [N_CH-1:0]             ch_enable,
    input  logic [CNT_W-1:0]            fill_cycles,
    input  logic [CNT_W-1:0]            mix_cycles,
    input  logic [CNT_W-1:0]            settle_cycles,
    output logic [N_CH-1:0]             valve_a,
    output logic [N_CH-1:0]             valve_b,
    output logic [N_CH-1:0]             mixer_en,
    output logic [N_CH-1:0]             det_sample,
    input  logic                        det_valid,
    input  logic [DATA_W-1:0]           det_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ch_width(N_CH)-1:0]   res_ch,
    output logic [DATA_W-1:0]           res_data,
    output logic                        res_timeout,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned CHW  = ch_width(N_CH);
    localparam int unsigned TO_W = $clog2(DET_TIMEOUT + 1);
    localparam int unsigned CW   = (CNT_W > TO_W) ? CNT_W : TO_W;

    state_e            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CW-1:0]     cnt_q;
    logic [N_CH-1:0]   mask_q;
    logic [CNT_W-1:0]  cfg_fill_q, cfg_mix_q, cfg_settle_q;
    logic [N_CH-1:0]   search_mask_c;
    logic              search_first_c;
    logic [CHW-1:0]    next_idx_c;
    logic              none_left_c;
    logic              capture_c;
    logic [N_CH-1:0]   onehot_c;

    // Same search serves the first-channel lookup (live mask) and advancing.
    ivd_next_channel #(
        .N_CH   (N_CH),
        .CHAN_W (CHW)
    ) u_next (
        .mask        (search_mask_c),
        .ptr         (ch_q),
        .first       (search_first_c),
        .next_idx_c  (next_idx_c),
        .none_left_c (none_left_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        capture_c      = 1'b0;
        search_first_c = (state_q == ST_IDLE);
        search_mask_c  = search_first_c ? ch_enable : mask_q;
        case (state_q)
            ST_IDLE:     if (start && !abort) state_d = none_left_c ? ST_FINISH : ST_FILL;
            ST_FILL:     if (cnt_q == CW'(cfg_fill_q) - CW'(1)) state_d = ST_MIX;
            ST_MIX:      if (cnt_q == CW'(cfg_mix_q) - CW'(1)) state_d = ST_SETTLE;
            ST_SETTLE:   if (cnt_q == CW'(cfg_settle_q) - CW'(1)) state_d = ST_SAMPLE;
            ST_SAMPLE:   state_d = ST_WAIT_DET;
            ST_WAIT_DET: begin
                if (det_valid || (cnt_q == CW'(DET_TIMEOUT - 1))) begin
                    state_d   = ST_REPORT;
                    capture_c = 1'b1;
                end
            end
            ST_REPORT:   if (res_ready) state_d = ST_NEXT;
            ST_NEXT:     state_d = none_left_c ? ST_FINISH : ST_FILL;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            capture_c = 1'b0;
        end
        if ((state_d == ST_FILL) && (state_q != ST_FILL)) ch_d = next_idx_c;
        onehot_c = N_CH'(1) << ch_d;
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            cfg_fill_q   <= '0;
            cfg_mix_q    <= '0;
            cfg_settle_q <= '0;
            valve_a      <= '0;
            valve_b      <= '0;
            mixer_en     <= '0;
            det_sample   <= '0;
            res_valid    <= 1'b0;
            res_ch       <= '0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ch_q <= ch_d;
            if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_REPORT))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
                mask_q       <= ch_enable;
                cfg_fill_q   <= CNT_W'(sat1(32'(fill_cycles)));
                cfg_mix_q    <= CNT_W'(sat1(32'(mix_cycles)));
                cfg_settle_q <= CNT_W'(sat1(32'(settle_cycles)));
            end
            if (capture_c) begin
                res_ch      <= ch_q;
                res_data    <= det_valid ? det_data : '0;
                res_timeout <= !det_valid;
            end
            valve_a    <= (state_d == ST_FILL)   ? onehot_c : '0;
            valve_b    <= (state_d == ST_FILL)   ? onehot_c : '0;
            mixer_en   <= (state_d == ST_MIX)    ? onehot_c : '0;
            det_sample <= (state_d == ST_SAMPLE) ? onehot_c : '0;
            res_valid  <= (state_d == ST_REPORT);
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_FINISH);
        end
    end

endmodule

// File: tb/tb_ivd_assay_sequencer.sv
// Scoreboard bench for ivd_assay_sequencer with a simple detector model.
module tb_ivd_assay_sequencer;

    localparam int NC = 12;

    logic        clk, rst_n, start, abort;
    logic [11:0] ch_enable;
    logic [15:0] fill_cycles, mix_cycles, settle_cycles;
    logic [11:0] valve_a, valve_b, mixer_en, det_sample;
    logic        det_valid;
    logic [11:0] det_data;
    logic        res_valid, res_ready;
    logic [3:0]  res_ch;
    logic [11:0] res_data;
    logic        res_timeout, busy, done;

    ivd_assay_sequencer #(
        .N_CH(12), .CNT_W(16), .DATA_W(12), .DET_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ch_enable(ch_enable), .fill_cycles(fill_cycles), .mix_cycles(mix_cycles),
        .settle_cycles(settle_cycles), .valve_a(valve_a), .valve_b(valve_b),
        .mixer_en(mixer_en), .det_sample(det_sample), .det_valid(det_valid),
        .det_data(det_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data), .res_timeout(res_timeout),
        .busy(busy), .done(done)
    );

    typedef struct {
        int          ch;
        logic [11:0] data;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   va_cnt[NC], vb_cnt[NC], mx_cnt[NC], ds_cnt[NC];
    int   busy_cnt, done_cnt, rv_cnt, oh_err;
    bit   det_never = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] det_val(input int c);
        case (c)
            0:       return 12'h0A5;
            2:       return 12'h3C1;
            default: return 12'(c * 37 + 5);
        endcase
    endfunction

    function automatic exp_t mk(input int c, input logic [11:0] d, input logic t);
        exp_t e;
        e.ch = c; e.data = d; e.to = t;
        return e;
    endfunction

    task automatic clr();
        for (int i = 0; i < NC; i++) begin
            va_cnt[i] = 0; vb_cnt[i] = 0; mx_cnt[i] = 0; ds_cnt[i] = 0;
        end
        busy_cnt = 0; done_cnt = 0; rv_cnt = 0; oh_err = 0;
    endtask

    task automatic run(input logic [11:0] m, input int f, input int mx, input int s);
        @(posedge clk); #1;
        clr();
        ch_enable = m; fill_cycles = 16'(f); mix_cycles = 16'(mx); settle_cycles = 16'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Detector: answers two cycles after the trigger unless told to stay silent.
    initial begin : det_model
        det_valid = 1'b0;
        det_data  = '0;
        forever begin : det_loop
            int c;
            @(negedge clk);
            if (det_sample != 0 && !det_never) begin
                c = 0;
                for (int i = 0; i < NC; i++) if (det_sample[i]) c = i;
                @(posedge clk);
                @(posedge clk); #1;
                det_valid = 1'b1;
                det_data  = det_val(c);
                @(posedge clk); #1;
                det_valid = 1'b0;
                det_data  = '0;
            end
        end
    end

    // Monitor: activity counters plus scoreboard comparison of every presented result.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (res_valid) rv_cnt++;
        for (int i = 0; i < NC; i++) begin
            if (valve_a[i])    va_cnt[i]++;
            if (valve_b[i])    vb_cnt[i]++;
            if (mixer_en[i])   mx_cnt[i]++;
            if (det_sample[i]) ds_cnt[i]++;
        end
        if ($countones(valve_a | valve_b | mixer_en | det_sample) > 1 ||
            (int'((valve_a | valve_b) != 0) + int'(mixer_en != 0) + int'(det_sample != 0)) > 1)
            oh_err++;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got ch %0d data %0h timeout %0b, required no result",
                         res_ch, res_data, res_timeout);
            end else begin
                check("sb_ch", 32'(res_ch), 32'(exp_q[0].ch));
                check("sb_data", 32'(res_data), 32'(exp_q[0].data));
                check("sb_timeout", 32'(res_timeout), 32'(exp_q[0].to));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        ch_enable = '0; fill_cycles = '0; mix_cycles = '0; settle_cycles = '0;
        clr();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_act", 32'(valve_a | valve_b | mixer_en | det_sample), 32'd0);
        check("rst_res", 32'({res_valid, done, res_timeout, res_ch, res_data}), 32'd0);
        #11 rst_n = 1'b1;

        // Two sparse channels with normal detector replies
        exp_q.push_back(mk(0, 12'h0A5, 1'b0));
        exp_q.push_back(mk(2, 12'h3C1, 1'b0));
        run(12'h005, 3, 4, 2);
        wait_done("t1", 200);
        check("t1_va0", 32'(va_cnt[0]), 32'd3);
        check("t1_vb0", 32'(vb_cnt[0]), 32'd3);
        check("t1_mx0", 32'(mx_cnt[0]), 32'd4);
        check("t1_va2", 32'(va_cnt[2]), 32'd3);
        check("t1_ch1_idle", 32'(va_cnt[1] + mx_cnt[1] + ds_cnt[1]), 32'd0);
        check("t1_ds", 32'(ds_cnt[0] + ds_cnt[2]), 32'd2);
        check("t1_busy", 32'(busy_cnt), 32'd29);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_rv", 32'(rv_cnt), 32'd2);
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // Empty mask: FINISH only
        run(12'h000, 3, 3, 3);
        wait_done("t2", 20);
        check("t2_busy", 32'(busy_cnt), 32'd1);
        check("t2_done", 32'(done_cnt), 32'd1);
        check("t2_rv", 32'(rv_cnt), 32'd0);
        check("t2_act", 32'(va_cnt[0] + mx_cnt[0] + ds_cnt[0]), 32'd0);

        // Zero durations on the highest channel
        exp_q.push_back(mk(11, det_val(11), 1'b0));
        run(12'h800, 0, 0, 0);
        wait_done("t3", 50);
        check("t3_va", 32'(va_cnt[11]), 32'd1);
        check("t3_mx", 32'(mx_cnt[11]), 32'd1);
        check("t3_ds", 32'(ds_cnt[11]), 32'd1);
        check("t3_busy", 32'(busy_cnt), 32'd9);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // Detector timeouts, sequencing continues
        det_never = 1;
        exp_q.push_back(mk(0, 12'h000, 1'b1));
        exp_q.push_back(mk(1, 12'h000, 1'b1));
        run(12'h003, 1, 1, 1);
        wait_done("t4", 200);
        check("t4_busy", 32'(busy_cnt), 32'd43);
        check("t4_done", 32'(done_cnt), 32'd1);
        check("t4_drain", 32'(exp_q.size()), 32'd0);
        det_never = 0;

        // Result stall for 20 cycles
        res_ready = 1'b0;
        exp_q.push_back(mk(1, det_val(1), 1'b0));
        exp_q.push_back(mk(2, det_val(2), 1'b0));
        run(12'h006, 2, 1, 1);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_seen", 32'(res_valid), 32'd1);
        repeat (20) @(negedge clk);
        check("t5_hold", 32'(res_valid), 32'd1);
        check("t5_no_fill", 32'(va_cnt[2]), 32'd0);
        check("t5_act_off", 32'(valve_a | valve_b | mixer_en | det_sample), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done("t5", 100);
        check("t5_va2", 32'(va_cnt[2]), 32'd2);
        check("t5_rv", 32'(rv_cnt), 32'd23);
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // Abort during MIX on channel 5
        run(12'h0A0, 2, 6, 1);
        n = 0;
        while (!mixer_en[5] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_mix5", 32'(mixer_en[5]), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_act", 32'(valve_a | valve_b | mixer_en | det_sample), 32'd0);
        check("t6_idle", 32'({busy, res_valid}), 32'd0);
        repeat (5) @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'd0);

        // start together with abort in IDLE does not launch
        @(posedge clk); #1;
        clr();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_sa_busy", 32'(busy_cnt), 32'd0);

        // Fresh run after abort
        exp_q.push_back(mk(5, det_val(5), 1'b0));
        exp_q.push_back(mk(7, det_val(7), 1'b0));
        run(12'h0A0, 2, 6, 1);
        wait_done("t6r", 200);
        check("t6r_va5", 32'(va_cnt[5]), 32'd2);
        check("t6r_mx5", 32'(mx_cnt[5]), 32'd6);
        check("t6r_mx7", 32'(mx_cnt[7]), 32'd6);
        check("t6r_done", 32'(done_cnt), 32'd1);
        check("t6r_drain", 32'(exp_q.size()), 32'd0);
        check("onehot", 32'(oh_err), 32'd0);

        // Asynchronous reset mid-FILL
        run(12'h001, 10, 1, 1);
        n = 0;
        while (!valve_a[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_fill", 32'(valve_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_valves", 32'(valve_a | valve_b), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_idle", 32'({busy, done}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
